rf_write_scheduler: RTL
=======================

Name: rf_write_scheduler

Overview:
- Sequences the single write port of the 32x32 register file between two writers:
  - the pipeline writeback stage (WB), which has fixed priority and is never back-pressured;
  - the long-latency unit (LL, mult/div), which uses a valid/ready handshake and a small result FIFO.
- Keeps a 32-entry pending-write scoreboard for LL destinations and raises a decode hazard stall on RAW/WAW conflicts.
- Sits between the WB stage / LL unit and the register file's reg_write/wr_reg/wr_data inputs.

Parameters:
- FIFO_DEPTH, 2, LL result FIFO entries (power of 2, >=2).
- MAX_OUTSTANDING, 4, maximum LL destinations pending at once (1..31).
- STARVE_LIMIT, 8, cycles the FIFO head may wait before an anti-starve request (feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- wb_valid  in  1  WB stage writes this cycle.
- wb_reg  in  5  WB destination.
- wb_data  in  32  WB data.
- ll_valid  in  1  LL result offered.
- ll_ready  out  1  LL result accepted when high with ll_valid.
- ll_reg  in  5  LL destination.
- ll_data  in  32  LL data.
- iss_valid  in  1  decode issues an LL op this cycle.
- iss_reg  in  5  LL op destination to reserve.
- dec_rs  in  5  decode source register 1.
- dec_rt  in  5  decode source register 2.
- hazard_stall  out  1  combinational; decode must hold.
- pending_cnt  out  $clog2(MAX_OUTSTANDING+1)  number of reserved destinations.
- starve_stall  out  1  registered; request WB to idle next cycle.
- rf_reg_write  out  1  registered write enable to register file.
- rf_wr_reg  out  5  registered write address.
- rf_wr_data  out  32  registered write data.

Behaviour:
- Reset, synchronous: after an edge with rst=1:
  - rf_reg_write=0, rf_wr_reg=0, rf_wr_data=0;
  - FIFO empty, scoreboard=0, pending_cnt=0, starve_stall=0, starve counter=0.
  - While rst=1: ll_ready=0 and hazard_stall=0. All in-flight LL results are discarded.
- Write-slot select, evaluated every cycle:
  - wb_valid && wb_reg!=0 -> WB;
  - else FIFO non-empty -> FIFO head, popped;
  - else idle.
  - The selection is registered into rf_* at the edge. rf_reg_write=1 only when a source was selected.
- Latency:
  - WB: 1 edge to rf_reg_write.
  - LL: accepted at edge E0, written at the earliest at E1. The LL path has no bypass around the FIFO.
- WB to r0: dropped; the write slot counts as free.
- LL handshake:
  - ll_ready = !fifo_full, evaluated at the start of the cycle. A pop in the same cycle does not make a full FIFO ready.
  - Push on ll_valid && ll_ready.
  - ll_reg==0: handshake completes, nothing is pushed.
- Scoreboard, pending[31:0]:
  - Set pending[iss_reg] at the edge when iss_valid && iss_reg!=0 && !hazard_stall.
  - Clear pending[rf_wr_reg] at the edge where a FIFO entry is registered into rf_*.
  - Set and clear of the same register on the same edge: set wins.
  - pending_cnt equals the popcount of the scoreboard at all times.
- hazard_stall is asserted when any of the following holds:
  - (dec_rs!=0 && pending[dec_rs]);
  - (dec_rt!=0 && pending[dec_rt]);
  - iss_valid && (pending[iss_reg] (WAW) || pending_cnt==MAX_OUTSTANDING).
- An LL result for a non-pending register is still written; the scoreboard is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit.

Optional Feature:
- Macro: RF_WSCHED_ANTISTARVE_EN.
- Defined:
  - The counter increments each cycle the FIFO is non-empty and not popped, and clears on pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, starve_stall is registered to 1. It stays high until the next pop, then drops at the following edge.
  - The pipeline contract is that WB idles while starve_stall=1. If wb_valid still arrives, WB keeps priority.
- Undefined: no counter; starve_stall tied to 0.

Decomposition:
- Shared package mips_pkg:
  - REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0;
  - typedef of the write request {reg, data}.
- One sub-module: rf_ll_fifo, a parameterised synchronous FIFO with push/pop/full/empty.
- Scoreboard, arbitration and output register stay in the top module.

Test Plan:
- Reset mid-operation:
  - Setup: 2 FIFO entries, 2 pending registers.
  - Stimulus: rst=1 for one edge.
  - Response: rf_reg_write=0, pending_cnt=0, ll_ready=0 during rst and 1 the cycle after.
- WB only:
  - Stimulus: wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF.
  - Response: next cycle rf_reg_write=1, rf_wr_reg=5, rf_wr_data=0xDEADBEEF.
  - Also: wb_reg=0 -> rf_reg_write=0.
- Collision:
  - Stimulus: iss r9; LL r9=0x11 accepted while wb_valid streams r3,r4.
  - Response: r3 and r4 written on consecutive cycles, then r9=0x11. pending[9] clears on that edge and pending_cnt goes 1->0.
- FIFO full:
  - Stimulus: FIFO_DEPTH=2 with WB busy every cycle; offer 3 LL results.
  - Response: 2 accepted, ll_ready=0 on the third until a pop, no data loss, in-order writes.
- Hazards:
  - Stimulus: pending r7, dec_rs=7 -> hazard_stall=1; dec_rs=0 with pending r0 impossible -> 0.
  - Stimulus: iss_reg=7 -> WAW stall; 4 pending + iss_valid -> stall.
  - Response: no scoreboard set while stalled.
- Anti-starve (macro defined):
  - Stimulus: WB busy for 10 cycles with 1 FIFO entry.
  - Response: starve_stall=1 after 8 waiting cycles; when WB idles the entry is written and starve_stall drops 1 edge later. Undefined macro: starve_stall stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared register-file constants and the write-request record used by the
// write scheduler and its LL result FIFO.
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] wreg;
      logic [DATA_W-1:0]     data;
   } wr_req_t;

endpackage

// File: rtl/rf_ll_fifo.sv
// Small synchronous FIFO for LL write requests. Pointers carry one extra bit
// so full and empty are distinguishable; the head is read combinationally.
module rf_ll_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wr_req_t push_data,
   input  logic    pop,
   output wr_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   wr_req_t       mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push && !full)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop && !empty)
         rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage has no reset; occupancy is defined by the pointers alone.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the register-file write port between WB (fixed priority) and the
// LL unit, tracking pending LL destinations. RF_WSCHED_ANTISTARVE_EN enables starve_stall.
module rf_write_scheduler
   import mips_pkg::*;
#(
   parameter int FIFO_DEPTH      = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 8,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  ll_valid,
   output logic                  ll_ready,
   input  logic [REG_ADDR_W-1:0] ll_reg,
   input  logic [DATA_W-1:0]     ll_data,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_reg,
   input  logic [REG_ADDR_W-1:0] dec_rs,
   input  logic [REG_ADDR_W-1:0] dec_rt,
   output logic                  hazard_stall,
   output logic [CNT_W-1:0]      pending_cnt,
   output logic                  starve_stall,
   output logic                  rf_reg_write,
   output logic [REG_ADDR_W-1:0] rf_wr_reg,
   output logic [DATA_W-1:0]     rf_wr_data
);

   wr_req_t fifo_head;
   wr_req_t ll_req;
   logic    fifo_full, fifo_empty;
   logic    fifo_push, fifo_pop;
   logic    wb_sel;

   logic [31:0]           pending_q, pending_d;
   logic [CNT_W-1:0]      pend_cnt;
   logic                  rf_reg_write_q, rf_reg_write_d;
   logic [REG_ADDR_W-1:0] rf_wr_reg_q, rf_wr_reg_d;
   logic [DATA_W-1:0]     rf_wr_data_q, rf_wr_data_d;

   // ll_ready reflects occupancy at cycle start; a same-cycle pop does not help.
   assign ll_ready  = !rst && !fifo_full;
   assign fifo_push = ll_valid && ll_ready && (ll_reg != REG_ZERO);
   assign wb_sel    = wb_valid && (wb_reg != REG_ZERO);
   assign fifo_pop  = !rst && !wb_sel && !fifo_empty;
   assign ll_req    = '{wreg: ll_reg, data: ll_data};

   rf_ll_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (ll_req),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < 32; i++)
         pend_cnt = pend_cnt + CNT_W'(pending_q[i]);
   end
   assign pending_cnt = pend_cnt;

   always_comb begin
      hazard_stall = 1'b0;
      if (!rst) begin
         if (dec_rs != REG_ZERO && pending_q[dec_rs])
            hazard_stall = 1'b1;
         if (dec_rt != REG_ZERO && pending_q[dec_rt])
            hazard_stall = 1'b1;
         if (iss_valid && (pending_q[iss_reg] || pend_cnt == CNT_W'(MAX_OUTSTANDING)))
            hazard_stall = 1'b1;
      end
   end

   // Clear first so that a reservation on the same edge wins.
   always_comb begin
      pending_d = pending_q;
      if (fifo_pop)
         pending_d[fifo_head.wreg] = 1'b0;
      if (iss_valid && iss_reg != REG_ZERO && !hazard_stall)
         pending_d[iss_reg] = 1'b1;
   end

   always_comb begin
      rf_reg_write_d = 1'b0;
      rf_wr_reg_d    = rf_wr_reg_q;
      rf_wr_data_d   = rf_wr_data_q;
      if (wb_sel) begin
         rf_reg_write_d = 1'b1;
         rf_wr_reg_d    = wb_reg;
         rf_wr_data_d   = wb_data;
      end else if (fifo_pop) begin
         rf_reg_write_d = 1'b1;
         rf_wr_reg_d    = fifo_head.wreg;
         rf_wr_data_d   = fifo_head.data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q      <= '0;
         rf_reg_write_q <= 1'b0;
         rf_wr_reg_q    <= '0;
         rf_wr_data_q   <= '0;
      end else begin
         pending_q      <= pending_d;
         rf_reg_write_q <= rf_reg_write_d;
         rf_wr_reg_q    <= rf_wr_reg_d;
         rf_wr_data_q   <= rf_wr_data_d;
      end
   end

   assign rf_reg_write = rf_reg_write_q;
   assign rf_wr_reg    = rf_wr_reg_q;
   assign rf_wr_data   = rf_wr_data_q;

`ifdef RF_WSCHED_ANTISTARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic          starve_q, starve_d;
   logic          pop_q, pop_d;

   // starve_stall is released one edge after the head has been written.
   always_comb begin
      pop_d        = fifo_pop;
      starve_cnt_d = starve_cnt_q;
      if (fifo_empty || fifo_pop)
         starve_cnt_d = '0;
      else if (starve_cnt_q != SW'(STARVE_LIMIT))
         starve_cnt_d = starve_cnt_q + 1'b1;
      starve_d = starve_q;
      if (pop_q)
         starve_d = 1'b0;
      else if (starve_cnt_d == SW'(STARVE_LIMIT))
         starve_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
         starve_q     <= 1'b0;
         pop_q        <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         starve_q     <= starve_d;
         pop_q        <= pop_d;
      end
   end

   assign starve_stall = starve_q;
`else
   assign starve_stall = 1'b0;
`endif

endmodule
